// File: rtl/lag_scan_sequencer.sv
// Per-frame lag sweep for PeakFinder: clear, scan lags 0..2*MAX_LAGS, settle, then present the result.
// Result valid 2*MAX_LAGS+4 cycles after accept; lag_ready low holds OUTPUT and blocks new frames.
module lag_scan_sequencer #(
  parameter int BITS_PER_XCORR = 6,
  parameter int MAX_LAGS       = 17,
  parameter int NO_PEAK_CODE   = 2**BITS_PER_XCORR - 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             xcorr_valid,
  output logic                             xcorr_ready,
  output logic                             busy,
  output logic                             peak_clear,
  output logic        [BITS_PER_XCORR-1:0] iterator,
  input  logic        [BITS_PER_XCORR-1:0] peak_lag,
  output logic                             lag_valid,
  input  logic                             lag_ready,
  output logic        [BITS_PER_XCORR-1:0] lag_index,
  output logic signed [BITS_PER_XCORR-1:0] lag_offset,
  output logic                             lag_none
);

  localparam int W = BITS_PER_XCORR;
  localparam logic [W-1:0] LAST_LAG = W'(2 * MAX_LAGS);
  localparam logic [W-1:0] CENTRE   = W'(MAX_LAGS);

  if (2 * MAX_LAGS + 1 > 2**BITS_PER_XCORR) begin : g_lag_width_chk
    $error("lag range 0..2*MAX_LAGS does not fit in BITS_PER_XCORR bits");
  end
  if (NO_PEAK_CODE <= 2 * MAX_LAGS) begin : g_no_peak_chk
    $error("NO_PEAK_CODE must lie above the scanned lag range");
  end

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SCAN,
    SETTLE,
    OUTPUT
  } state_t;

  state_t       state, state_nxt;
  logic [W-1:0] iter_q, iter_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      iter_q <= '0;
    end else begin
      state  <= state_nxt;
      iter_q <= iter_nxt;
    end
  end

  // The counter only moves in SCAN, so it reads 0 in every other state.
  always_comb begin
    state_nxt = state;
    iter_nxt  = '0;
    case (state)
      IDLE:   if (xcorr_valid) state_nxt = CLEAR;
      CLEAR:  state_nxt = SCAN;
      SCAN: begin
        if (iter_q == LAST_LAG) state_nxt = SETTLE;
        else                    iter_nxt  = iter_q + W'(1);
      end
      SETTLE: state_nxt = OUTPUT;
      OUTPUT: if (lag_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign xcorr_ready = (state == IDLE);
  assign busy        = (state != IDLE);
  assign peak_clear  = (state == CLEAR);
  assign lag_valid   = (state == OUTPUT);
  assign iterator    = iter_q;

  // Any code outside the scanned range, including NO_PEAK_CODE, means no peak.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lag_index  <= '0;
      lag_offset <= '0;
      lag_none   <= 1'b0;
    end else if (state == SETTLE) begin
      if (peak_lag <= LAST_LAG) begin
        lag_index  <= peak_lag;
        lag_offset <= peak_lag - CENTRE;
        lag_none   <= 1'b0;
      end else begin
        lag_index  <= '0;
        lag_offset <= '0;
        lag_none   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lag_scan_sequencer.sv
// Bench for lag_scan_sequencer with a behavioural PeakFinder (threshold 1000) driven by a per-frame vector.
module tb_lag_scan_sequencer;

  localparam int W    = 6;
  localparam int ML   = 17;
  localparam int NL   = 2 * ML + 1;
  localparam int NOPK = 63;
  localparam int THR  = 1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic xcorr_valid = 1'b0;
  logic lag_ready = 1'b0;
  logic xcorr_ready, busy, peak_clear, lag_valid, lag_none;
  logic [W-1:0] iterator, peak_lag, lag_index;
  logic signed [W-1:0] lag_offset;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_acc = -1000;
  int xv[NL];

  int pk_val;
  logic [W-1:0] pk_lag;
  logic force_en = 1'b0;
  logic [W-1:0] force_val = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // PeakFinder: strict first maximum above threshold, cleared by rst or peak_clear.
  always @(posedge clk) begin
    if (rst || peak_clear) begin
      pk_val <= THR;
      pk_lag <= W'(NOPK);
    end else if (int'(iterator) < NL && xv[int'(iterator)] > pk_val) begin
      pk_val <= xv[int'(iterator)];
      pk_lag <= iterator;
    end
  end
  assign peak_lag = force_en ? force_val : pk_lag;

  lag_scan_sequencer #(.BITS_PER_XCORR(W), .MAX_LAGS(ML), .NO_PEAK_CODE(NOPK)) dut (
    .clk(clk), .rst(rst),
    .xcorr_valid(xcorr_valid), .xcorr_ready(xcorr_ready), .busy(busy),
    .peak_clear(peak_clear), .iterator(iterator), .peak_lag(peak_lag),
    .lag_valid(lag_valid), .lag_ready(lag_ready),
    .lag_index(lag_index), .lag_offset(lag_offset), .lag_none(lag_none)
  );

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_peak();
    int best = -1;
    int bv = THR;
    for (int i = 0; i < NL; i++)
      if (xv[i] > bv) begin
        bv = xv[i];
        best = i;
      end
    return best;
  endfunction

  task automatic fill(input int base, input int lag, input int val);
    for (int i = 0; i < NL; i++) xv[i] = base;
    if (lag >= 0) xv[lag] = val;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ctl"}, {busy, xcorr_ready, peak_clear, lag_valid, lag_none}, 5'b01000);
    check({tag, "_iter"}, iterator, 0);
    check({tag, "_res"}, {lag_index, lag_offset}, 0);
  endtask

  // exp_idx < 0 means no peak expected; delay = cycles lag_ready is held low once valid.
  task automatic run_frame(input int exp_idx, input int delay, input bit b2b, input string nm);
    int c0, errs, n, e_idx, e_off, e_none;
    e_none = (exp_idx < 0) ? 1 : 0;
    e_idx  = e_none ? 0 : exp_idx;
    e_off  = e_none ? 0 : exp_idx - ML;
    n = 0;
    while (xcorr_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_accept_rdy"}, xcorr_ready, 1);
    if (b2b) check({nm, "_period"}, cyc - last_acc, NL + 4);
    xcorr_valid = 1'b1;
    c0 = cyc;
    last_acc = c0;
    @(negedge clk);
    xcorr_valid = 1'b0;
    errs = 0;
    if (peak_clear !== 1'b1 || iterator !== '0 || busy !== 1'b1 || xcorr_ready !== 1'b0) errs++;
    for (int k = 0; k < NL; k++) begin
      @(negedge clk);
      if (peak_clear !== 1'b0 || int'(iterator) != k || lag_valid !== 1'b0 || busy !== 1'b1) errs++;
    end
    @(negedge clk);
    if (iterator !== '0 || peak_clear !== 1'b0 || lag_valid !== 1'b0 || busy !== 1'b1) errs++;
    check({nm, "_sweep"}, errs, 0);
    lag_ready = (delay == 0);
    @(negedge clk);
    check({nm, "_valid_at_38"}, lag_valid, 1);
    check({nm, "_cycle"}, cyc - c0, 2 * ML + 4);
    check({nm, "_index"}, lag_index, e_idx);
    check({nm, "_offset"}, lag_offset, e_off);
    check({nm, "_none"}, lag_none, e_none);
    errs = 0;
    for (int d = 0; d < delay; d++) begin
      xcorr_valid = 1'($urandom_range(1, 0));
      @(negedge clk);
      if (lag_valid !== 1'b1 || xcorr_ready !== 1'b0 || busy !== 1'b1 ||
          lag_index !== e_idx[W-1:0] || lag_offset !== e_off[W-1:0] || lag_none !== e_none[0]) errs++;
    end
    if (delay > 0) check({nm, "_hold"}, errs, 0);
    xcorr_valid = 1'b0;
    lag_ready = 1'b1;
    @(negedge clk);
    check({nm, "_release"}, {xcorr_ready, lag_valid, busy, peak_clear}, 4'b1000);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int fv[4];
    int n;
    fv = '{34, 35, 40, 63};
    fill(100, -1, 0);
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);

    fill(100, 20, 5000);
    run_frame(20, 0, 0, "peak");
    fill(500, -1, 0);
    run_frame(-1, 0, 0, "nopeak");

    fill(100, 0, 9000);
    run_frame(0, 0, 0, "b2b_a");
    fill(100, 34, 2000);
    run_frame(34, 0, 1, "b2b_b");

    fill(100, 7, 3000);
    run_frame(7, 10, 0, "backpressure");

    fill(100, -1, 0);
    force_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      force_val = W'(fv[i]);
      run_frame((fv[i] <= 2 * ML) ? fv[i] : -1, 0, 0, "forced_code");
    end
    force_en = 1'b0;

    // Reset mid-scan; previous frame left nonzero results to be cleared.
    fill(100, 20, 5000);
    run_frame(20, 0, 0, "pre_rst");
    xcorr_valid = 1'b1;
    @(negedge clk);
    xcorr_valid = 1'b0;
    n = 0;
    while (iterator !== W'(10) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rst_at_iter10", iterator, 10);
    rst = 1'b1;
    #1;
    check_reset_vals("rst_async");
    @(negedge clk);
    check_reset_vals("rst_next");
    rst = 1'b0;
    fill(100, 5, 4000);
    run_frame(5, 0, 0, "post_rst");

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < NL; i++)
        xv[i] = int'($urandom_range((r % 2 == 0) ? 1400 : 1002, 0));
      run_frame(ref_peak(), int'($urandom_range(3, 0)), 0, "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
